letter_slot_scheduler: RTL and testbench

- Sequences the random letter generator (ch/speed/x/y) for the falling-letter typing game.
- Owns NUM_SLOTS on-screen letter slots and samples generator outputs into a free slot every SPAWN_PERIOD frames.
- On each frame tick, advances every active letter by its speed and retires letters that reach the bottom as misses.
- Matches keyboard characters against active letters to score hits, and exposes a slot read port to the VGA renderer.

---
 rtl/letter_game_pkg.sv | 22 ++
 rtl/slot_best_match.sv | 34 +++
 rtl/letter_slot_scheduler.sv | 246 ++++++++++++++++++++++++
 tb/tb_letter_slot_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/letter_game_pkg.sv
// Shared types and constants for the falling-letter typing game.
// Slot record layout and scheduler state codes used across the letter datapath.
package letter_game_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MOVE  = 2'd1;
  localparam logic [1:0] ST_SPAWN = 2'd2;
  localparam logic [1:0] ST_HIT   = 2'd3;

  localparam int ASCII_A      = 65;
  localparam int LETTER_COUNT = 26;
  localparam int COL_PITCH    = 9;

  typedef struct packed {
    logic       active;
    logic [7:0] ch;
    logic [2:0] speed;
    logic [8:0] x;
    logic [9:0] y;
  } slot_t;

endpackage

// File: rtl/slot_best_match.sv
// Running-best update for the key-match scan: keeps the matching active slot
// with the largest x; slots arrive in ascending index, so a strict > keeps ties on the lowest index.
module slot_best_match #(
  parameter int IW = 3
) (
  input  logic          best_found,
  input  logic [8:0]    best_x,
  input  logic [IW-1:0] best_idx,
  input  logic          cand_active,
  input  logic [7:0]    cand_ch,
  input  logic [8:0]    cand_x,
  input  logic [IW-1:0] cand_idx,
  input  logic [7:0]    key_ch,
  output logic          nxt_found,
  output logic [8:0]    nxt_x,
  output logic [IW-1:0] nxt_idx
);

  logic take;

  assign take = cand_active && (cand_ch == key_ch) && (!best_found || (cand_x > best_x));

  always_comb begin
    nxt_found = best_found;
    nxt_x     = best_x;
    nxt_idx   = best_idx;
    if (take) begin
      nxt_found = 1'b1;
      nxt_x     = cand_x;
      nxt_idx   = cand_idx;
    end
  end

endmodule

// File: rtl/letter_slot_scheduler.sv
// Letter slot scheduler: spawns generator letters into free slots, moves them each
// frame, retires bottom hits as misses and matches key presses to score hits.
module letter_slot_scheduler
  import letter_game_pkg::*;
#(
  parameter int         NUM_SLOTS    = 8,
  parameter int         SPAWN_PERIOD = 40,
  parameter logic [8:0] BOTTOM_X     = 9'd470,
  localparam int        IW           = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          clear,
  input  logic          frame_tick,
  input  logic [7:0]    gen_ch,
  input  logic [2:0]    gen_speed,
  input  logic [9:0]    gen_y,
  input  logic          key_valid,
  input  logic [7:0]    key_ch,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_active,
  output logic [7:0]    rd_ch,
  output logic [8:0]    rd_x,
  output logic [9:0]    rd_y,
  output logic          hit_pulse,
  output logic          miss_pulse,
  output logic [15:0]   score,
  output logic [7:0]    miss_cnt,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  localparam int SCW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD + 1) : 1;

  slot_t slots_q [NUM_SLOTS];
  slot_t slots_d [NUM_SLOTS];

  logic [1:0]     state_q, state_d;
  logic [IW:0]    step_q, step_d;
  logic [SCW-1:0] spawn_cnt_q, spawn_cnt_d;
  logic           frame_pend_q, frame_pend_d;
  logic           key_pend_q, key_pend_d;
  logic [7:0]     key_ch_q, key_ch_d;
  logic           best_found_q, best_found_d;
  logic [8:0]     best_x_q, best_x_d;
  logic [IW-1:0]  best_idx_q, best_idx_d;
  logic [15:0]    score_q, score_d;
  logic [7:0]     miss_cnt_q, miss_cnt_d;
  logic           hit_q, hit_d;
  logic           miss_q, miss_d;

  logic [IW-1:0]  sel;
  logic [9:0]     x_sum;
  logic           last_slot;
  logic           free_found;
  logic [IW-1:0]  free_idx;
  logic           scan_found;
  logic [8:0]     scan_x;
  logic [IW-1:0]  scan_idx;
  logic           frame_clr;
  logic           key_clr;

  assign sel       = step_q[IW-1:0];
  // 10-bit sum so a letter near the bottom cannot wrap back to the top.
  assign x_sum     = {1'b0, slots_q[sel].x} + {7'b0, slots_q[sel].speed};
  assign last_slot = (sel == IW'(NUM_SLOTS - 1));

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slots_q[i].active) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  slot_best_match #(.IW(IW)) u_best (
    .best_found  (best_found_q),
    .best_x      (best_x_q),
    .best_idx    (best_idx_q),
    .cand_active (slots_q[sel].active),
    .cand_ch     (slots_q[sel].ch),
    .cand_x      (slots_q[sel].x),
    .cand_idx    (sel),
    .key_ch      (key_ch_q),
    .nxt_found   (scan_found),
    .nxt_x       (scan_x),
    .nxt_idx     (scan_idx)
  );

  always_comb begin
    slots_d      = slots_q;
    state_d      = state_q;
    step_d       = step_q;
    spawn_cnt_d  = spawn_cnt_q;
    frame_pend_d = frame_pend_q;
    key_pend_d   = key_pend_q;
    key_ch_d     = key_ch_q;
    best_found_d = best_found_q;
    best_x_d     = best_x_q;
    best_idx_d   = best_idx_q;
    score_d      = score_q;
    miss_cnt_d   = miss_cnt_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    frame_clr    = 1'b0;
    key_clr      = 1'b0;

    if (clear) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots_d[i] = '0;
      state_d      = ST_IDLE;
      step_d       = '0;
      spawn_cnt_d  = '0;
      frame_pend_d = 1'b0;
      key_pend_d   = 1'b0;
      best_found_d = 1'b0;
      score_d      = '0;
      miss_cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run && frame_pend_q) begin
            state_d = ST_MOVE;
            step_d  = '0;
          end else if (run && key_pend_q) begin
            state_d      = ST_HIT;
            step_d       = '0;
            best_found_d = 1'b0;
          end
        end
        ST_MOVE: begin
          if (slots_q[sel].active) begin
            if (x_sum >= {1'b0, BOTTOM_X}) begin
              slots_d[sel].active = 1'b0;
              miss_d              = 1'b1;
              miss_cnt_d          = (miss_cnt_q == 8'hFF) ? miss_cnt_q : miss_cnt_q + 8'd1;
            end else begin
              slots_d[sel].x = x_sum[8:0];
            end
          end
          step_d = step_q + 1'b1;
          if (last_slot) begin
            frame_clr = 1'b1;
            step_d    = '0;
            if (spawn_cnt_q == SCW'(SPAWN_PERIOD - 1)) begin
              spawn_cnt_d = '0;
              state_d     = ST_SPAWN;
            end else begin
              spawn_cnt_d = spawn_cnt_q + 1'b1;
              state_d     = ST_IDLE;
            end
          end
        end
        ST_SPAWN: begin
          if (free_found) begin
            slots_d[free_idx].active = 1'b1;
            slots_d[free_idx].ch     = gen_ch;
            slots_d[free_idx].speed  = gen_speed;
            slots_d[free_idx].x      = 9'd0;
            slots_d[free_idx].y      = gen_y;
          end
          state_d = ST_IDLE;
        end
        ST_HIT: begin
          // step == NUM_SLOTS is the resolve cycle after the last slot was scanned.
          if (step_q == (IW+1)'(NUM_SLOTS)) begin
            if (best_found_q) begin
              slots_d[best_idx_q].active = 1'b0;
              hit_d                      = 1'b1;
              score_d                    = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
            end
            key_clr = 1'b1;
            step_d  = '0;
            state_d = ST_IDLE;
          end else begin
            best_found_d = scan_found;
            best_x_d     = scan_x;
            best_idx_d   = scan_idx;
            step_d       = step_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // A flag already set swallows a repeat event; clearing wins over a same-cycle repeat.
      if (frame_clr) frame_pend_d = 1'b0;
      else if (run && frame_tick) frame_pend_d = 1'b1;

      if (key_clr) begin
        key_pend_d = 1'b0;
      end else if (run && key_valid && !key_pend_q) begin
        key_pend_d = 1'b1;
        key_ch_d   = key_ch;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
      state_q      <= ST_IDLE;
      step_q       <= '0;
      spawn_cnt_q  <= '0;
      frame_pend_q <= 1'b0;
      key_pend_q   <= 1'b0;
      key_ch_q     <= '0;
      best_found_q <= 1'b0;
      best_x_q     <= '0;
      best_idx_q   <= '0;
      score_q      <= '0;
      miss_cnt_q   <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      slots_q      <= slots_d;
      state_q      <= state_d;
      step_q       <= step_d;
      spawn_cnt_q  <= spawn_cnt_d;
      frame_pend_q <= frame_pend_d;
      key_pend_q   <= key_pend_d;
      key_ch_q     <= key_ch_d;
      best_found_q <= best_found_d;
      best_x_q     <= best_x_d;
      best_idx_q   <= best_idx_d;
      score_q      <= score_d;
      miss_cnt_q   <= miss_cnt_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  assign rd_active  = slots_q[rd_idx].active;
  assign rd_ch      = slots_q[rd_idx].ch;
  assign rd_x       = slots_q[rd_idx].x;
  assign rd_y       = slots_q[rd_idx].y;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign score      = score_q;
  assign miss_cnt   = miss_cnt_q;
  assign busy       = (state_q != ST_IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_letter_slot_scheduler.sv
// Bench for letter_slot_scheduler: transaction-level game model checked every cycle,
// directed scenarios with literal expectations, then randomized play.
module tb_letter_slot_scheduler;

  localparam int N  = 8;
  localparam int P  = 3;
  localparam int BX = 470;

  logic        clk = 1'b0;
  logic        rst, run, clear, frame_tick, key_valid;
  logic [7:0]  gen_ch, key_ch;
  logic [2:0]  gen_speed;
  logic [9:0]  gen_y;
  logic [2:0]  rd_idx;
  logic        rd_active, hit_pulse, miss_pulse, busy;
  logic [7:0]  rd_ch, miss_cnt;
  logic [8:0]  rd_x;
  logic [9:0]  rd_y;
  logic [15:0] score;
  logic [1:0]  state_dbg;

  letter_slot_scheduler #(.NUM_SLOTS(N), .SPAWN_PERIOD(P), .BOTTOM_X(9'd470)) dut (
    .clk(clk), .rst(rst), .run(run), .clear(clear), .frame_tick(frame_tick),
    .gen_ch(gen_ch), .gen_speed(gen_speed), .gen_y(gen_y),
    .key_valid(key_valid), .key_ch(key_ch), .rd_idx(rd_idx),
    .rd_active(rd_active), .rd_ch(rd_ch), .rd_x(rd_x), .rd_y(rd_y),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score),
    .miss_cnt(miss_cnt), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;
  int miss_seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
  endtask

  // behavioural game model
  int         m_act [N];
  logic [7:0] m_ch  [N];
  int         m_x   [N];
  int         m_y   [N];
  int         m_spd [N];
  int         m_score, m_miss, m_scnt;
  bit         m_fp, m_kp;
  logic [7:0] m_kch;
  int         cyc = 0;
  int         idle_edge, hit_edge, spawn_edge, fclr_edge, kclr_edge;
  int         miss_q [$];
  bit         e_hit, e_miss;

  task m_clear(input int n);
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_ch[i] = 0; m_x[i] = 0; m_y[i] = 0; m_spd[i] = 0;
    end
    m_score = 0; m_miss = 0; m_scnt = 0; m_fp = 0; m_kp = 0; m_kch = 0;
    idle_edge = n + 1; hit_edge = -1; spawn_edge = -1; fclr_edge = -1; kclr_edge = -1;
    miss_q.delete();
    e_hit = 0; e_miss = 0;
  endtask

  task m_move(input int n);
    int nx;
    for (int i = 0; i < N; i++) begin
      if (m_act[i] != 0) begin
        nx = m_x[i] + m_spd[i];
        if (nx >= BX) begin
          m_act[i] = 0;
          miss_q.push_back(n + 1 + i);
        end else m_x[i] = nx;
      end
    end
    fclr_edge = n + N;
    m_scnt++;
    if (m_scnt == P) begin
      m_scnt = 0; spawn_edge = n + N + 1; idle_edge = n + N + 2;
    end else idle_edge = n + N + 1;
  endtask

  task m_hit(input int n);
    int bx, bi;
    bx = -1; bi = -1;
    for (int i = 0; i < N; i++)
      if (m_act[i] != 0 && m_ch[i] == m_kch && m_x[i] > bx) bx = m_x[i];
    for (int i = 0; i < N; i++)
      if (bi < 0 && bx >= 0 && m_act[i] != 0 && m_ch[i] == m_kch && m_x[i] == bx) bi = i;
    if (bi >= 0) begin
      m_act[bi] = 0;
      hit_edge = n + N + 1;
    end
    kclr_edge = n + N + 1;
    idle_edge = n + N + 2;
  endtask

  task m_spawn();
    int f;
    f = -1;
    for (int i = N - 1; i >= 0; i--) if (m_act[i] == 0) f = i;
    if (f >= 0) begin
      m_act[f] = 1; m_ch[f] = gen_ch; m_spd[f] = gen_speed; m_x[f] = 0; m_y[f] = gen_y;
    end
  endtask

  task m_step(input int n);
    bit ofp, okp;
    e_hit = 0; e_miss = 0;
    if (clear) begin
      m_clear(n);
    end else begin
      ofp = m_fp; okp = m_kp;
      if (miss_q.size() > 0 && miss_q[0] == n) begin
        void'(miss_q.pop_front());
        e_miss = 1;
        if (m_miss < 255) m_miss++;
      end
      if (hit_edge == n) begin
        e_hit = 1; hit_edge = -1;
        if (m_score < 65535) m_score++;
      end
      if (spawn_edge == n) begin m_spawn(); spawn_edge = -1; end
      if (fclr_edge == n) begin m_fp = 0; fclr_edge = -1; end
      if (kclr_edge == n) begin m_kp = 0; kclr_edge = -1; end
      if (n >= idle_edge && run) begin
        if (ofp) m_move(n);
        else if (okp) m_hit(n);
      end
      if (run && frame_tick && !ofp) m_fp = 1;
      if (run && key_valid && !okp) begin m_kp = 1; m_kch = key_ch; end
    end
  endtask

  // per-cycle compare against the model
  always @(posedge clk) begin
    if (rst) m_clear(-1);
    else begin
      cyc++;
      m_step(cyc);
    end
    #1;
    if (!rst) begin
      if (miss_pulse === 1'b1) miss_seen++;
      check("hit_pulse", hit_pulse, e_hit);
      check("miss_pulse", miss_pulse, e_miss);
      check("score", score, m_score);
      check("miss_cnt", miss_cnt, m_miss);
      check("busy", busy, (idle_edge > cyc + 1));
      if (idle_edge <= cyc + 1) begin
        check("rd_active", rd_active, m_act[rd_idx]);
        check("rd_ch", rd_ch, m_ch[rd_idx]);
        check("rd_x", rd_x, m_x[rd_idx]);
        check("rd_y", rd_y, m_y[rd_idx]);
      end
    end
  end

  // driver tasks
  task automatic wait_quiet();
    int q, t;
    q = 0; t = 0;
    while (q < 3 && t < 200) begin
      @(negedge clk);
      t++;
      if (!busy) q++; else q = 0;
    end
    if (q < 3) begin
      n_checks++;
      $display("FAIL wait_quiet: busy=%0d after %0d cycles, required 0", busy, t);
    end
  endtask

  task automatic do_tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    wait_quiet();
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic sel(input int i);
    rd_idx = 3'(i);
    #1;
  endtask

  initial begin
    int k;
    rst = 1'b1; run = 1'b1; clear = 1'b0; frame_tick = 1'b0; key_valid = 1'b0;
    key_ch = 8'd0; gen_ch = 8'd65; gen_speed = 3'd0; gen_y = 10'd0; rd_idx = 3'd0;
    repeat (3) @(negedge clk);
    sel(0);
    check("lit_reset_active", rd_active, 0);
    check("lit_reset_score", score, 0);
    check("lit_reset_busy", busy, 0);
    rst = 1'b0;

    // spawn cadence: one spawn per P frames
    gen_ch = 8'd72; gen_y = 10'd27; gen_speed = 3'd2;
    repeat (2) do_tick();
    sel(0); check("lit_no_spawn_yet", rd_active, 0);
    do_tick();
    gen_ch = 8'd66; gen_y = 10'd40; gen_speed = 3'd1;
    sel(0);
    check("lit_spawn_active", rd_active, 1);
    check("lit_spawn_ch", rd_ch, 72);
    check("lit_spawn_y", rd_y, 27);
    check("lit_spawn_x", rd_x, 0);
    do_tick();
    sel(0); check("lit_move_x2", rd_x, 2);
    repeat (2) do_tick();
    sel(0); check("lit_move_x6", rd_x, 6);
    sel(1); check("lit_slot1_active", rd_active, 1);
    check("lit_slot1_ch", rd_ch, 66);

    // paused: ticks ignored
    run = 1'b0;
    repeat (3) do_tick();
    sel(0); check("lit_paused_x", rd_x, 6);
    run = 1'b1;

    // bottom boundary: 469 stays, next step misses
    do_clear();
    gen_ch = 8'd77; gen_y = 10'd100; gen_speed = 3'd7;
    repeat (3) do_tick();
    gen_ch = 8'd66; gen_speed = 3'd0;
    repeat (67) do_tick();
    sel(0);
    check("lit_x469_active", rd_active, 1);
    check("lit_x469_x", rd_x, 469);
    check("lit_x469_miss_cnt", miss_cnt, 0);
    sel(7); check("lit_full_slot7", rd_active, 1);
    miss_seen = 0;
    do_tick();
    sel(0);
    check("lit_miss_inactive", rd_active, 0);
    check("lit_miss_cnt", miss_cnt, 1);
    check("lit_miss_pulses", miss_seen, 1);

    // tie on x goes to lowest index; hit latency
    do_clear();
    for (int i = 0; i < 6; i++) begin
      gen_ch = (i == 2 || i == 5) ? 8'd75 : 8'(65 + i);
      gen_y = 10'(i * 9); gen_speed = 3'd0;
      repeat (3) do_tick();
    end
    @(negedge clk); key_valid = 1'b1; key_ch = 8'd75;
    @(negedge clk); key_valid = 1'b0;
    k = 0;
    for (int j = 1; j <= 30 && k == 0; j++) begin
      @(posedge clk); #1;
      if (hit_pulse) k = j;
    end
    check("lit_hit_latency", k, N + 2);
    wait_quiet();
    sel(2); check("lit_tie_slot2", rd_active, 0);
    sel(5); check("lit_tie_slot5", rd_active, 1);
    check("lit_tie_score", score, 1);

    do_clear();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin sel(i); check("lit_clear_active", rd_active, 0); end
    check("lit_clear_score", score, 0);
    check("lit_clear_miss", miss_cnt, 0);

    // frame and key together: move first, then match; repeat key dropped
    gen_ch = 8'd90; gen_y = 10'd3; gen_speed = 3'd1;
    repeat (3) do_tick();
    gen_speed = 3'd0;
    repeat (9) do_tick();
    sel(0); check("lit_x9", rd_x, 9);
    @(negedge clk); frame_tick = 1'b1; key_valid = 1'b1; key_ch = 8'd90;
    @(negedge clk); frame_tick = 1'b0; key_valid = 1'b0;
    repeat (3) @(negedge clk);
    key_valid = 1'b1;
    @(negedge clk); key_valid = 1'b0;
    wait_quiet();
    sel(0);
    check("lit_simul_inactive", rd_active, 0);
    check("lit_simul_x10", rd_x, 10);
    sel(1); check("lit_simul_slot1_kept", rd_active, 1);
    check("lit_simul_score", score, 1);

    // randomized play
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      frame_tick = ($urandom_range(0, 3) == 0);
      key_valid  = ($urandom_range(0, 5) == 0);
      key_ch     = 8'(65 + $urandom_range(0, 25));
      gen_ch     = 8'(65 + $urandom_range(0, 25));
      gen_speed  = 3'($urandom_range(0, 7));
      gen_y      = 10'($urandom_range(0, 621));
      run        = ($urandom_range(0, 19) != 0);
      clear      = ($urandom_range(0, 999) == 0);
      rd_idx     = 3'($urandom_range(0, N - 1));
    end
    @(negedge clk);
    frame_tick = 1'b0; key_valid = 1'b0; clear = 1'b0; run = 1'b1;
    wait_quiet();

    // async reset in the middle of a move pass
    gen_speed = 3'd1;
    repeat (P) do_tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("lit_pre_reset_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("lit_async_busy", busy, 0);
    check("lit_async_score", score, 0);
    check("lit_async_miss", miss_cnt, 0);
    for (int i = 0; i < N; i++) begin sel(i); check("lit_async_active", rd_active, 0); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
